// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one DRAM bus among NUM_REQ requesters, one transaction in flight.
// Optional read-response watchdog enabled by defining MEMORY_BUS_ARB_TIMEOUT_EN.
module memory_bus_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned SRC_W          = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_is_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           rsp_error,
  output logic                           dram_req_valid,
  input  logic                           dram_req_ready,
  output logic                           dram_req_is_write,
  output logic [ADDR_W-1:0]              dram_req_addr,
  output logic [DATA_W-1:0]              dram_req_data,
  output logic [SRC_W-1:0]               dram_req_src,
  input  logic                           dram_rsp_valid,
  input  logic [DATA_W-1:0]              dram_rsp_data,
  input  logic [SRC_W-1:0]               dram_rsp_src,
  output logic                           busy,
  output logic                           err_src_mismatch
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitResp} state_e;

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    rr_ptr_q;
  logic [SRC_W-1:0]    gnt_idx, cand;
  logic                gnt_found;
  logic                rsp_take, timeout_hit;
  logic                is_write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [SRC_W-1:0]    src_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_error_q;
  logic                err_q;

  // First requesting port at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = SRC_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && state_q == StIdle && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign rsp_take = (state_q == StWaitResp) && dram_rsp_valid;

`ifdef MEMORY_BUS_ARB_TIMEOUT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == StIssue && dram_req_ready && !is_write_q) begin
      cnt_q <= '0;
    end else if (state_q == StWaitResp) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  // A real response in the same cycle takes priority over the watchdog.
  assign timeout_hit = (state_q == StWaitResp) && !dram_rsp_valid &&
                       (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (gnt_found) state_d = StIssue;
      StIssue:    if (dram_req_ready) state_d = is_write_q ? StIdle : StWaitResp;
      StWaitResp: if (rsp_take || timeout_hit) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      src_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;
      rsp_error_q <= 1'b0;
      if (state_q == StIdle && gnt_found) begin
        rr_ptr_q   <= SRC_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
        is_write_q <= req_is_write[gnt_idx];
        addr_q     <= req_addr[gnt_idx];
        data_q     <= req_data[gnt_idx];
        src_q      <= gnt_idx;
      end
      if (rsp_take) begin
        rsp_valid_q[src_q] <= 1'b1;
        rsp_data_q         <= dram_rsp_data;
      end else if (timeout_hit) begin
        rsp_valid_q[src_q] <= 1'b1;
        rsp_data_q         <= '0;
        rsp_error_q        <= 1'b1;
      end
      // Stray responses and wrong tags are both flagged; the data still goes to src_q.
      if (dram_rsp_valid && (state_q != StWaitResp || dram_rsp_src != src_q)) err_q <= 1'b1;
    end
  end

  assign dram_req_valid    = (state_q == StIssue);
  assign dram_req_is_write = is_write_q;
  assign dram_req_addr     = addr_q;
  assign dram_req_data     = data_q;
  assign dram_req_src      = src_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_error         = rsp_error_q;
  assign busy              = (state_q != StIdle);
  assign err_src_mismatch  = err_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: expected grants, DRAM packets and responses are
// queued when stimulus is driven and compared as the DUT produces them.
module tb_memory_bus_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned SRC_W   = 2;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  src;
  } pkt_t;

  typedef struct packed {
    logic [3:0]  port;
    logic [63:0] data;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NUM_REQ-1:0]             req_valid = '0;
  logic [NUM_REQ-1:0]             req_is_write = '0;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]             req_ready, rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic                           rsp_error;
  logic                           dram_req_valid;
  logic                           dram_req_ready = 1'b0;
  logic                           dram_req_is_write;
  logic [ADDR_W-1:0]              dram_req_addr;
  logic [DATA_W-1:0]              dram_req_data;
  logic [SRC_W-1:0]               dram_req_src;
  logic                           dram_rsp_valid = 1'b0;
  logic [DATA_W-1:0]              dram_rsp_data = '0;
  logic [SRC_W-1:0]               dram_rsp_src = '0;
  logic                           busy, err_src_mismatch;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  bit   auto_drop = 1'b1;
  int   acc0;
  int   exp_gnt[$];
  pkt_t exp_pkt[$];
  rsp_t exp_rsp[$];
  pkt_t mon_pkt;
  rsp_t mon_rsp;

  memory_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_is_write(req_is_write), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
    .dram_req_is_write(dram_req_is_write), .dram_req_addr(dram_req_addr),
    .dram_req_data(dram_req_data), .dram_req_src(dram_req_src),
    .dram_rsp_valid(dram_rsp_valid), .dram_rsp_data(dram_rsp_data),
    .dram_rsp_src(dram_rsp_src),
    .busy(busy), .err_src_mismatch(err_src_mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; requesters drop valid after the cycle they were granted.
  task automatic tick();
    logic [NUM_REQ-1:0] g;
    @(negedge clk);
    g = req_ready;
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~g;
  endtask

  task automatic issue(input int p, input bit we, input logic [63:0] a, input logic [63:0] d);
    req_valid[p]    = 1'b1;
    req_is_write[p] = we;
    req_addr[p]     = a;
    req_data[p]     = d;
    exp_gnt.push_back(p);
    exp_pkt.push_back('{we, a, d, 2'(p)});
  endtask

  task automatic respond(input int src, input logic [63:0] d, input int port);
    dram_rsp_valid = 1'b1;
    dram_rsp_src   = 2'(src);
    dram_rsp_data  = d;
    exp_rsp.push_back('{4'(1 << port), d, 1'b0});
    tick();
    dram_rsp_valid = 1'b0;
    check("rsp_latency", rsp_valid, 64'(1 << port));
    check("idle_after_rsp", busy, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_dram_valid", dram_req_valid, 0);
    check("rst_dram_addr", dram_req_addr, 0);
    check("rst_dram_data", dram_req_data, 0);
    check("rst_dram_src", dram_req_src, 0);
    check("rst_dram_we", dram_req_is_write, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_err", err_src_mismatch, 0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (req_ready != '0) begin
        check("gnt_onehot", $countones(req_ready), 1);
        if (exp_gnt.size() == 0) check("gnt_unexpected", req_ready, 0);
        else check("gnt_port", req_ready, 64'(1) << exp_gnt.pop_front());
      end
      if (busy && req_valid != '0) check("gnt_while_busy", req_ready, 0);
      if (dram_req_valid && dram_req_ready) begin
        n_acc++;
        if (exp_pkt.size() == 0) begin
          check("dram_unexpected", dram_req_valid, 0);
        end else begin
          mon_pkt = exp_pkt.pop_front();
          check("dram_we", dram_req_is_write, mon_pkt.we);
          check("dram_addr", dram_req_addr, mon_pkt.addr);
          check("dram_data", dram_req_data, mon_pkt.data);
          check("dram_src", dram_req_src, mon_pkt.src);
        end
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          mon_rsp = exp_rsp.pop_front();
          check("rsp_port", rsp_valid, mon_rsp.port);
          check("rsp_data", rsp_data, mon_rsp.data);
          check("rsp_error", rsp_error, mon_rsp.err);
        end
      end
    end
  end

  initial begin
    do_reset();

    // Single read from port 2.
    dram_req_ready = 1'b1;
    issue(2, 1'b0, 64'h100, 64'hDEAD);
    tick();
    check("read_issue_valid", dram_req_valid, 1);
    check("read_issue_src", dram_req_src, 2);
    tick();
    check("read_wait_busy", busy, 1);
    repeat (4) tick();
    respond(2, 64'h1122334455667788, 2);
    tick();
    check("read_no_err", err_src_mismatch, 0);

    // Fairness: all ports hold writes continuously.
    do_reset();
    auto_drop = 1'b0;
    for (int p = 0; p < 4; p++) issue(p, 1'b1, 64'h1000 + 64'(p * 8), 64'hA0 + 64'(p));
    for (int p = 0; p < 4; p++) begin
      exp_gnt.push_back(p);
      exp_pkt.push_back('{1'b1, 64'h1000 + 64'(p * 8), 64'hA0 + 64'(p), 2'(p)});
    end
    acc0 = n_acc;
    repeat (16) tick();
    req_valid = '0;
    auto_drop = 1'b1;
    check("fair_writes_16cyc", n_acc - acc0, 8);
    check("fair_gnt_drained", exp_gnt.size(), 0);
    tick();

    // Backpressure: port 1 write stalls in ISSUE while ports 3 and 0 wait.
    dram_req_ready = 1'b0;
    issue(1, 1'b1, 64'hA0, 64'hBEEF);
    tick();
    issue(3, 1'b1, 64'hB0, 64'h3333);
    issue(0, 1'b1, 64'hC0, 64'h0000_0000_0000_0C0C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", dram_req_valid, 1);
      check("bp_addr", dram_req_addr, 64'hA0);
      check("bp_data", dram_req_data, 64'hBEEF);
      check("bp_src", dram_req_src, 1);
      check("bp_no_grant", req_ready, 0);
    end
    dram_req_ready = 1'b1;
    repeat (5) tick();
    check("bp_gnt_drained", exp_gnt.size(), 0);
    check("bp_pkt_drained", exp_pkt.size(), 0);

    // Tag mismatch: port 1 read answered with src 3.
    issue(1, 1'b0, 64'h200, 64'h0);
    tick();
    tick();
    tick();
    respond(3, 64'hCAFE, 1);
    check("mismatch_set", err_src_mismatch, 1);
    repeat (3) tick();
    check("mismatch_sticky", err_src_mismatch, 1);
    do_reset();

    // Response while idle is ignored but flagged.
    dram_rsp_valid = 1'b1;
    dram_rsp_src   = 2'd0;
    tick();
    dram_rsp_valid = 1'b0;
    check("stray_err", err_src_mismatch, 1);
    check("stray_no_rsp", rsp_valid, 0);
    do_reset();

    // Reset while waiting for a read response.
    issue(0, 1'b0, 64'h300, 64'h5);
    tick();
    tick();
    tick();
    check("midread_busy", busy, 1);
    do_reset();
    repeat (5) tick();
    check("midread_idle", busy, 0);

`ifdef MEMORY_BUS_ARB_TIMEOUT_EN
    // Read with no DRAM response: watchdog fires 16 cycles after WAIT_RESP entry.
    issue(2, 1'b0, 64'h400, 64'h0);
    tick();
    tick();
    exp_rsp.push_back('{4'b0100, 64'h0, 1'b1});
    repeat (15) tick();
    check("timeout_not_early", rsp_valid, 0);
    tick();
    check("timeout_rsp", rsp_valid, 4'b0100);
    check("timeout_err", rsp_error, 1);
    tick();
`endif

    check("end_gnt_q", exp_gnt.size(), 0);
    check("end_pkt_q", exp_pkt.size(), 0);
    check("end_rsp_q", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
